// File: rtl/expr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : expr_pkg
// Purpose  : Shared constants for the expression recognizer and evaluator.
//            - One-hot state encoding of the recognizer FSM.
//            - ASCII character constants.
//            - Character-class codes produced by expr_char_class.
// Revision : 1.0 - initial release
// ============================================================================
package expr_pkg;

    // One-hot recognizer states
    localparam int         STATE_W = 4;
    localparam logic [3:0] S_OPND  = 4'b0001;  // expecting an operand
    localparam logic [3:0] S_NUM   = 4'b0010;  // inside a number
    localparam logic [3:0] S_OPTR  = 4'b0100;  // expecting operator or ')'
    localparam logic [3:0] S_ERR   = 4'b1000;  // absorbing error

    // ASCII characters of interest
    localparam logic [7:0] C_ASCII_0     = 8'h30;
    localparam logic [7:0] C_ASCII_9     = 8'h39;
    localparam logic [7:0] C_ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] C_ASCII_MINUS = 8'h2D;
    localparam logic [7:0] C_ASCII_STAR  = 8'h2A;
    localparam logic [7:0] C_ASCII_SLASH = 8'h2F;
    localparam logic [7:0] C_ASCII_LP    = 8'h28;
    localparam logic [7:0] C_ASCII_RP    = 8'h29;
    localparam logic [7:0] C_ASCII_SP    = 8'h20;

    // Character classes
    localparam int         CLS_W   = 3;
    localparam logic [2:0] C_DIGIT = 3'd0;
    localparam logic [2:0] C_OP    = 3'd1;
    localparam logic [2:0] C_LP    = 3'd2;
    localparam logic [2:0] C_RP    = 3'd3;
    localparam logic [2:0] C_SP    = 3'd4;
    localparam logic [2:0] C_OTHER = 3'd5;

endpackage : expr_pkg
`default_nettype wire

// File: rtl/expr_char_class.sv
`default_nettype none
// ============================================================================
// Module   : expr_char_class
// Purpose  : Purely combinational ASCII -> character-class mapper.
// Ports    : i_char [7:0]       - ASCII character
//            o_cls  [CLS_W-1:0] - class code (C_DIGIT/C_OP/C_LP/C_RP/C_SP/C_OTHER)
// Params   : ALLOW_SPACE - when 0, a space maps to C_OTHER
// Revision : 1.0 - initial release
// ============================================================================
module expr_char_class
    import expr_pkg::*;
#(
    parameter bit ALLOW_SPACE = 1'b1
) (
    input  logic [7:0]       i_char,
    output logic [CLS_W-1:0] o_cls
);

    always_comb begin
        o_cls = C_OTHER;
        if ((i_char >= C_ASCII_0) && (i_char <= C_ASCII_9)) begin
            o_cls = C_DIGIT;
        end else if ((i_char == C_ASCII_PLUS) || (i_char == C_ASCII_MINUS) ||
                     (i_char == C_ASCII_STAR) || (i_char == C_ASCII_SLASH)) begin
            o_cls = C_OP;
        end else if (i_char == C_ASCII_LP) begin
            o_cls = C_LP;
        end else if (i_char == C_ASCII_RP) begin
            o_cls = C_RP;
        end else if (ALLOW_SPACE && (i_char == C_ASCII_SP)) begin
            o_cls = C_SP;
        end
    end

endmodule : expr_char_class
`default_nettype wire

// File: rtl/expr_checker.sv
`default_nettype none
// ============================================================================
// Module   : expr_checker
// Purpose  : Streaming recognizer for arithmetic expressions with multi-digit
//            numbers, + - * /, nested parentheses and optional whitespace.
//            Reports whether the prefix seen so far is a complete expression,
//            plus a sticky error with the index of the first bad character.
// Ports    : clk                  - clock, rising edge
//            clr_n                - asynchronous active-low reset
//            sync_clr             - synchronous restart (beats in_valid)
//            in_valid             - in carries a character this cycle
//            in       [7:0]       - ASCII character
//            out                  - prefix is a complete valid expression
//            err                  - sticky error
//            depth    [DEPTH_W-1:0] - open-parenthesis count
//            err_pos  [POS_W-1:0] - 0-based index of first offending char
// Revision : 1.0 - initial release
// ============================================================================
module expr_checker
    import expr_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int MAX_DEPTH   = 7,
    parameter bit ALLOW_SPACE = 1'b1,
    parameter int POS_W       = 8,
    // A depth of 0 would collapse the port to zero width; keep one bit.
    localparam int DEPTH_W    = (MAX_DEPTH > 0) ? $clog2(MAX_DEPTH + 1) : 1
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               sync_clr,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [POS_W-1:0]   err_pos
);

    localparam int LEN_W = $clog2(MAX_DIGITS + 1);

    logic [STATE_W-1:0] r_state,   w_state;
    logic [LEN_W-1:0]   r_len,     w_len;
    logic [DEPTH_W-1:0] r_depth,   w_depth;
    logic [POS_W-1:0]   r_pos,     w_pos;
    logic [POS_W-1:0]   r_err_pos, w_err_pos;
    logic               r_out,     w_out;
    logic [CLS_W-1:0]   w_cls;

    expr_char_class #(
        .ALLOW_SPACE (ALLOW_SPACE)
    ) u_char_class (
        .i_char (in),
        .o_cls  (w_cls)
    );

    // Next-state and counter logic
    always_comb begin
        w_state   = r_state;
        w_len     = r_len;
        w_depth   = r_depth;
        w_pos     = r_pos;
        w_err_pos = r_err_pos;

        if (in_valid) begin
            if (r_pos != {POS_W{1'b1}}) begin
                w_pos = r_pos + POS_W'(1);
            end

            case (r_state)
                S_OPND: begin
                    case (w_cls)
                        C_DIGIT: begin
                            w_state = S_NUM;
                            w_len   = LEN_W'(1);
                        end
                        C_LP: begin
                            if (32'(r_depth) < MAX_DEPTH) begin
                                w_depth = r_depth + DEPTH_W'(1);
                            end else begin
                                w_state = S_ERR;
                            end
                        end
                        C_SP:    ;
                        default: w_state = S_ERR;
                    endcase
                end
                S_NUM, S_OPTR: begin
                    case (w_cls)
                        C_DIGIT: begin
                            // Digits only extend a number; after a space they are an error.
                            if ((r_state == S_NUM) && (32'(r_len) < MAX_DIGITS)) begin
                                w_len = r_len + LEN_W'(1);
                            end else begin
                                w_state = S_ERR;
                            end
                        end
                        C_OP: begin
                            w_state = S_OPND;
                            w_len   = '0;
                        end
                        C_RP: begin
                            if (r_depth != '0) begin
                                w_depth = r_depth - DEPTH_W'(1);
                                w_state = S_OPTR;
                                w_len   = '0;
                            end else begin
                                w_state = S_ERR;
                            end
                        end
                        C_SP: begin
                            w_state = S_OPTR;
                            w_len   = '0;
                        end
                        default: w_state = S_ERR;
                    endcase
                end
                default: w_state = S_ERR;
            endcase

            // Capture the index of the character that caused the error only once.
            if ((w_state == S_ERR) && (r_state != S_ERR)) begin
                w_err_pos = r_pos;
            end
        end

        w_out = ((w_state == S_NUM) || (w_state == S_OPTR)) && (w_depth == '0);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_OPND;
            r_len     <= '0;
            r_depth   <= '0;
            r_pos     <= '0;
            r_err_pos <= '0;
            r_out     <= 1'b0;
        end else if (sync_clr) begin
            r_state   <= S_OPND;
            r_len     <= '0;
            r_depth   <= '0;
            r_pos     <= '0;
            r_err_pos <= '0;
            r_out     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_len     <= w_len;
            r_depth   <= w_depth;
            r_pos     <= w_pos;
            r_err_pos <= w_err_pos;
            r_out     <= w_out;
        end
    end

    assign out     = r_out;
    assign err     = (r_state == S_ERR);
    assign depth   = r_depth;
    assign err_pos = r_err_pos;

endmodule : expr_checker
`default_nettype wire

// File: tb/tb_expr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_checker
// Purpose  : Self-checking bench for expr_checker. Four instances share one
//            character stream; each vector names the instance it checks:
//              0 defaults, 1 MAX_DIGITS=1, 2 MAX_DEPTH=2, 3 ALLOW_SPACE=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_expr_checker;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       sync_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] char_in = 8'h00;

    logic       out0, out1, out2, out3;
    logic       err0, err1, err2, err3;
    logic [2:0] dep0, dep1, dep3;
    logic [1:0] dep2;
    logic [7:0] ep0, ep1, ep2, ep3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    expr_checker u_def (
        .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .in_valid(in_valid), .in(char_in),
        .out(out0), .err(err0), .depth(dep0), .err_pos(ep0));
    expr_checker #(.MAX_DIGITS(1)) u_d1 (
        .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .in_valid(in_valid), .in(char_in),
        .out(out1), .err(err1), .depth(dep1), .err_pos(ep1));
    expr_checker #(.MAX_DEPTH(2)) u_p2 (
        .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .in_valid(in_valid), .in(char_in),
        .out(out2), .err(err2), .depth(dep2), .err_pos(ep2));
    expr_checker #(.ALLOW_SPACE(1'b0)) u_ns (
        .clk(clk), .clr_n(clr_n), .sync_clr(sync_clr), .in_valid(in_valid), .in(char_in),
        .out(out3), .err(err3), .depth(dep3), .err_pos(ep3));

    typedef struct {
        int       sel;
        bit       vld;
        bit       sc;
        bit [7:0] ch;
        bit       o;
        bit       e;
        int       d;
        int       ep;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input int sel, input bit o, input bit e,
                           input int d, input int ep);
        logic       a_o, a_e;
        logic [7:0] a_d, a_ep;
        case (sel)
            0:       begin a_o = out0; a_e = err0; a_d = {5'd0, dep0}; a_ep = ep0; end
            1:       begin a_o = out1; a_e = err1; a_d = {5'd0, dep1}; a_ep = ep1; end
            2:       begin a_o = out2; a_e = err2; a_d = {6'd0, dep2}; a_ep = ep2; end
            default: begin a_o = out3; a_e = err3; a_d = {5'd0, dep3}; a_ep = ep3; end
        endcase
        chk({tag, ".out"},   {31'd0, a_o}, {31'd0, o});
        chk({tag, ".err"},   {31'd0, a_e}, {31'd0, e});
        chk({tag, ".depth"}, {24'd0, a_d}, d);
        if (e) chk({tag, ".err_pos"}, {24'd0, a_ep}, ep);
    endtask

    // Drive one cycle, sample 1 time unit after the rising edge.
    task automatic step(input bit v, input bit sc, input bit [7:0] ch);
        in_valid = v;
        sync_clr = sc;
        char_in  = ch;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic add(input int sel, input bit vld, input bit sc, input byte ch,
                       input bit o, input bit e, input int d, input int ep);
        vec_t v;
        v.sel = sel; v.vld = vld; v.sc = sc; v.ch = ch;
        v.o = o; v.e = e; v.d = d; v.ep = ep;
        vecs.push_back(v);
    endtask

    initial begin
        // ---- vector table: sel, vld, sclr, char, out, err, depth, err_pos ----
        // "12+3" on defaults
        add(0, 0, 1, "x", 0, 0, 0, 0);
        add(0, 1, 0, "1", 1, 0, 0, 0);
        add(0, 1, 0, "2", 1, 0, 0, 0);
        add(0, 1, 0, "+", 0, 0, 0, 0);
        add(0, 1, 0, "3", 1, 0, 0, 0);
        // "1+23" with single-digit operands
        add(1, 0, 1, "x", 0, 0, 0, 0);
        add(1, 1, 0, "1", 1, 0, 0, 0);
        add(1, 1, 0, "+", 0, 0, 0, 0);
        add(1, 1, 0, "2", 1, 0, 0, 0);
        add(1, 1, 0, "3", 0, 1, 0, 3);
        // "((4))" then "(((" with depth limit 2
        add(2, 0, 1, "x", 0, 0, 0, 0);
        add(2, 1, 0, "(", 0, 0, 1, 0);
        add(2, 1, 0, "(", 0, 0, 2, 0);
        add(2, 1, 0, "4", 0, 0, 2, 0);
        add(2, 1, 0, ")", 0, 0, 1, 0);
        add(2, 1, 0, ")", 1, 0, 0, 0);
        add(2, 0, 1, "x", 0, 0, 0, 0);
        add(2, 1, 0, "(", 0, 0, 1, 0);
        add(2, 1, 0, "(", 0, 0, 2, 0);
        add(2, 1, 0, "(", 0, 1, 2, 2);
        // "7)" unmatched close
        add(0, 0, 1, "x", 0, 0, 0, 0);
        add(0, 1, 0, "7", 1, 0, 0, 0);
        add(0, 1, 0, ")", 0, 1, 0, 1);
        // "1 2" with spaces allowed
        add(0, 0, 1, "x", 0, 0, 0, 0);
        add(0, 1, 0, "1", 1, 0, 0, 0);
        add(0, 1, 0, " ", 1, 0, 0, 0);
        add(0, 1, 0, "2", 0, 1, 0, 2);
        // "1 " with spaces disallowed
        add(3, 0, 1, "x", 0, 0, 0, 0);
        add(3, 1, 0, "1", 1, 0, 0, 0);
        add(3, 1, 0, " ", 0, 1, 0, 1);
        // "12345": four digits legal, fifth is the error
        add(0, 0, 1, "x", 0, 0, 0, 0);
        add(0, 1, 0, "1", 1, 0, 0, 0);
        add(0, 1, 0, "2", 1, 0, 0, 0);
        add(0, 1, 0, "3", 1, 0, 0, 0);
        add(0, 1, 0, "4", 1, 0, 0, 0);
        add(0, 1, 0, "5", 0, 1, 0, 4);
        // "(5+" unclosed paren / trailing operator are recoverable
        add(0, 0, 1, "x", 0, 0, 0, 0);
        add(0, 1, 0, "(", 0, 0, 1, 0);
        add(0, 1, 0, "5", 0, 0, 1, 0);
        add(0, 1, 0, "+", 0, 0, 1, 0);
        add(0, 1, 0, "6", 0, 0, 1, 0);
        add(0, 1, 0, ")", 1, 0, 0, 0);

        // ---- reset state ----
        #2;
        chk_dut("reset_async", 0, 0, 0, 0, 0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        chk_dut("reset_after", 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].vld, vecs[i].sc, vecs[i].ch);
            chk_dut($sformatf("vec%0d", i), vecs[i].sel, vecs[i].o, vecs[i].e,
                    vecs[i].d, vecs[i].ep);
        end

        // ---- in_valid low holds everything; garbage on in is ignored ----
        step(0, 1, "x");
        step(1, 0, "1");
        step(1, 0, "+");
        for (int k = 0; k < 5; k++) begin
            step(0, 0, ")");
            chk_dut($sformatf("hold%0d", k), 0, 0, 0, 0, 0);
        end
        step(1, 0, "2");
        chk_dut("hold_resume", 0, 1, 0, 0, 0);
        step(1, 0, ")");                       // position 3 if the idle cycles were not counted
        chk_dut("hold_errpos", 0, 0, 1, 0, 3);

        // ---- sync_clr beats in_valid; '(' is dropped ----
        step(1, 1, "(");
        chk_dut("sclr_drop", 0, 0, 0, 0, 0);
        step(1, 0, ")");                       // depth still 0, and this is index 0
        chk_dut("sclr_pos", 0, 0, 1, 0, 0);

        // ---- asynchronous clear while in error ----
        @(negedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        chk_dut("async_clr", 0, 0, 0, 0, 0);
        #1;
        clr_n = 1'b1;
        step(1, 0, "9");
        chk_dut("async_then9", 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_expr_checker
`default_nettype wire

// File: doc/expr_checker.md
# expr_checker

Streaming, parametrised arithmetic-expression recognizer: consumes one ASCII character per accepted cycle and reports whether the prefix seen so far is a complete, well-formed expression. It is the successor to the single-digit `digit (op digit)*` recognizer. It adds:
- multi-digit numbers,
- the full operator set,
- nested parentheses,
- optional whitespace,
- an input valid qualifier,
- a sticky error with the error position.

It sits behind the character-stream source and feeds the expression evaluator's start/abort logic.

## Interface
- `MAX_DIGITS`, 4: max digits per number; 1 gives single-digit operands.
- `MAX_DEPTH`, 7: max parenthesis nesting depth; 0 disables `(` and `)`.
- `ALLOW_SPACE`, 1: when set, ASCII 0x20 is whitespace; when clear, it is an illegal character.
- `POS_W`, 8: width of the character position counter.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `clr_n`, in, 1: reset, asynchronous, active-low.
- `sync_clr`, in, 1: synchronous restart; has the same effect as reset, on the clock edge.
- `in_valid`, in, 1: `in` carries a character this cycle.
- `in`, in, 8: ASCII character.
- `out`, out, 1: prefix consumed so far is a complete valid expression.
- `err`, out, 1: sticky; the stream is irrecoverably invalid.
- `depth`, out, $clog2(MAX_DEPTH+1): current open-paren count.
- `err_pos`, out, POS_W: 0-based index of the first offending character; valid while `err`=1.

## Operation
Character classes:
- DIGIT: `0`–`9`.
- OP: `+`, `-`, `*`, `/`.
- LP: `(`.
- RP: `)`.
- SP: space, only when ALLOW_SPACE=1.
- OTHER: everything else.

States (one-hot):
- **S_OPND**: expecting an operand; this is the reset state.
  - DIGIT → S_NUM, len=1.
  - LP → if depth<MAX_DEPTH then depth+1 and stay, else S_ERR.
  - SP → stay.
  - Anything else → S_ERR.
- **S_NUM**: inside a number.
  - DIGIT → if len<MAX_DIGITS then len+1, else S_ERR.
  - OP → S_OPND.
  - RP → if depth>0 then depth−1 and go to S_OPTR, else S_ERR.
  - SP → S_OPTR.
  - Anything else → S_ERR.
- **S_OPTR**: operand finished, expecting an operator or `)`.
  - OP → S_OPND.
  - RP → as in S_NUM.
  - SP → stay.
  - DIGIT, LP, OTHER → S_ERR.
- **S_ERR**: absorbing; leaves only on `clr_n`=0 or `sync_clr`=1.

Output and counter rules:
- `out` = 1 iff the state is S_NUM or S_OPTR and depth==0. `out` is registered and is updated from the next-state values.
- `err` = 1 iff the state is S_ERR.
- `err_pos` captures the position counter on the transition into S_ERR and then holds.
- The position counter increments on every accepted character and saturates at 2^POS_W−1.
- `len` is $clog2(MAX_DIGITS+1) bits wide and is cleared on entry to S_OPND or S_OPTR.

## Timing
- Reset values (`clr_n`=0 or `sync_clr`): state S_OPND, `out`=0, `err`=0, `depth`=0, `err_pos`=0, position=0, `len`=0.
- Latency: a character accepted at edge k is reflected in `out`, `err` and `depth` immediately after edge k. Latency is 1 cycle, with no combinational path from `in` to the outputs.
- `in_valid`=0: all state, counters and outputs hold; `in` is ignored.
- `sync_clr` has priority over `in_valid`; the character presented in the same cycle is dropped.
- `clr_n` asserted mid-expression: immediate asynchronous return to the reset values; no partial state survives.
- Depth at MAX_DEPTH followed by `(` → error. Depth 0 followed by `)` → error. `depth` never wraps.
- A number of exactly MAX_DIGITS digits is legal; the digit after that is the error.
- A trailing operator or an unclosed `(` gives `out`=0 with `err`=0, because the expression is still recoverable.

## Structure
- Package `expr_pkg` holds:
  - the state encoding localparams S_OPND, S_NUM, S_OPTR, S_ERR;
  - the ASCII character constants;
  - the class encoding DIGIT/OP/LP/RP/SP/OTHER.
- Sub-module `expr_char_class` is purely combinational. It maps `in`, gated by ALLOW_SPACE, to the class code. It is reused by the evaluator.
- The top level holds the FSM, the `len`/`depth`/position counters and the output registers.

## Test plan
- Defaults; stream `12+3`, one character per cycle → `out` sequence 1,1,0,1; `err`=0 throughout.
- MAX_DIGITS=1; stream `1+23` → after `2`: `out`=1; after `3`: `err`=1, `err_pos`=3, `out`=0.
- MAX_DEPTH=2; stream `((4))` → `depth` 1,2,2,1,0; `out`=1 only after the final `)`. Then stream `(((` → `err` on the third `(`, `err_pos`=2.
- Stream `7)` → `err`=1, `err_pos`=1. Stream `1 2` with ALLOW_SPACE=1 → `err` at `2`, `err_pos`=2. With ALLOW_SPACE=0 → `err` at the space, `err_pos`=1.
- Hold `in_valid`=0 for 5 cycles mid-stream with garbage on `in` → no state change; pulse `sync_clr` together with `in_valid`=1 → reset values, character dropped.
- Drop `clr_n` asynchronously between edges while in S_ERR → `err`=0 and `out`=0 before the next edge; `9` is then accepted with `out`=1.
